// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system ID boot-time checker.
package sysid_checker_pkg;

    // Check sequencer states
    typedef enum logic [2:0] {
        S_ADDR0 = 3'd0,
        S_ADDR1 = 3'd1,
        S_CMP   = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    // Word addresses of the sysid slave
    localparam logic SYSID_ID_ADDR = 1'b0;
    localparam logic SYSID_TS_ADDR = 1'b1;

    // Exact 32-bit equality used for both compared words
    function automatic logic word_match(input logic [31:0] observed, input logic [31:0] expected);
        return (observed == expected);
    endfunction

endpackage

// File: rtl/sysid_recheck_timer.sv
// Period counter for automatic rechecks. Counts while enabled, clears on
// request, and pulses tick on the terminal count (PERIOD-1).
module sysid_recheck_timer #(
    parameter int PERIOD = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count_r;

    assign tick = enable && (count_r == CW'(PERIOD - 1));

    // Cycle counter: restarts on clear or after each terminal count
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable) begin
            if (tick) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1'b1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// Boot-time sequencer for the sysid slave: reads the ID and build timestamp,
// compares them, retries a bounded number of times and then grants or
// withholds system_enable. Define SYSID_CHECKER_PERIODIC_EN to add automatic
// rechecks every RECHECK_PERIOD cycles while passing.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1639603229,
    parameter int          SETTLE_CYCLES      = 2,
    parameter int          MAX_RETRIES        = 3,
    parameter int          RECHECK_PERIOD     = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        mismatch,
    output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] retry_count,
    output logic        system_enable
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [SW-1:0]   settle_cnt_r;
    logic [SW-1:0]   settle_cnt_nxt_s;
    logic            last_settle_s;
    logic            id_match_s;
    logic            ts_match_s;
    logic            timer_fire_s;
    logic            recheck_s;

    logic            sysid_address_nxt_s;
    logic [31:0]     id_value_nxt_s;
    logic [31:0]     timestamp_nxt_s;
    logic            busy_nxt_s;
    logic            done_nxt_s;
    logic            id_ok_nxt_s;
    logic            ts_ok_nxt_s;
    logic            mismatch_nxt_s;
    logic [RW-1:0]   retry_count_nxt_s;
    logic            system_enable_nxt_s;

    assign last_settle_s = (settle_cnt_r == SW'(SETTLE_CYCLES - 1));
    assign id_match_s    = word_match(id_value, EXPECTED_ID);
    assign ts_match_s    = word_match(timestamp, EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECKER_PERIODIC_EN
    sysid_recheck_timer #(
        .PERIOD (RECHECK_PERIOD)
    ) u_recheck_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_r != S_PASS),
        .enable (state_r == S_PASS),
        .tick   (timer_fire_s)
    );
`else
    // No automatic rechecks in this build; the period only matters with the timer.
    assign timer_fire_s = 1'b0 & (RECHECK_PERIOD == 0);
`endif

    // start and the timer are merged so a coincident pair gives one recheck
    assign recheck_s = (start | timer_fire_s) & ((state_r == S_PASS) | (state_r == S_FAIL));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= S_ADDR0;
            settle_cnt_r <= {SW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            settle_cnt_r <= settle_cnt_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_ADDR0: begin
                if (last_settle_s) state_nxt_s = S_ADDR1;
                else               state_nxt_s = S_ADDR0;
            end
            S_ADDR1: begin
                if (last_settle_s) state_nxt_s = S_CMP;
                else               state_nxt_s = S_ADDR1;
            end
            S_CMP: begin
                if (id_match_s && ts_match_s)             state_nxt_s = S_PASS;
                else if (retry_count < RW'(MAX_RETRIES))  state_nxt_s = S_ADDR0;
                else                                      state_nxt_s = S_FAIL;
            end
            S_PASS, S_FAIL: begin
                if (recheck_s) state_nxt_s = S_ADDR0;
                else           state_nxt_s = state_r;
            end
            default: state_nxt_s = S_ADDR0;
        endcase
    end

    // Next values of the registered outputs and the settle counter
    always_comb begin
        settle_cnt_nxt_s    = {SW{1'b0}};
        id_value_nxt_s      = id_value;
        timestamp_nxt_s     = timestamp;
        id_ok_nxt_s         = id_ok;
        ts_ok_nxt_s         = ts_ok;
        mismatch_nxt_s      = mismatch;
        retry_count_nxt_s   = retry_count;
        system_enable_nxt_s = system_enable;
        case (state_r)
            S_ADDR0: begin
                if (last_settle_s) id_value_nxt_s   = sysid_readdata;
                else               settle_cnt_nxt_s = settle_cnt_r + SW'(1'b1);
            end
            S_ADDR1: begin
                if (last_settle_s) timestamp_nxt_s  = sysid_readdata;
                else               settle_cnt_nxt_s = settle_cnt_r + SW'(1'b1);
            end
            S_CMP: begin
                id_ok_nxt_s = id_match_s;
                ts_ok_nxt_s = ts_match_s;
                if (id_match_s && ts_match_s) begin
                    system_enable_nxt_s = 1'b1;
                end else if (retry_count < RW'(MAX_RETRIES)) begin
                    retry_count_nxt_s = retry_count + RW'(1'b1);
                end else begin
                    mismatch_nxt_s      = 1'b1;
                    system_enable_nxt_s = 1'b0;
                end
            end
            S_PASS, S_FAIL: begin
                if (recheck_s) begin
                    retry_count_nxt_s = {RW{1'b0}};
                    mismatch_nxt_s    = 1'b0;
                end else begin
                    retry_count_nxt_s = retry_count;
                end
            end
            default: settle_cnt_nxt_s = {SW{1'b0}};
        endcase
        if (state_nxt_s == S_ADDR1) sysid_address_nxt_s = SYSID_TS_ADDR;
        else                        sysid_address_nxt_s = SYSID_ID_ADDR;
        busy_nxt_s = (state_nxt_s == S_ADDR0) || (state_nxt_s == S_ADDR1) || (state_nxt_s == S_CMP);
        done_nxt_s = (state_nxt_s == S_PASS);
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sysid_address <= SYSID_ID_ADDR;
            id_value      <= 32'd0;
            timestamp     <= 32'd0;
            busy          <= 1'b1;
            done          <= 1'b0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            mismatch      <= 1'b0;
            retry_count   <= {RW{1'b0}};
            system_enable <= 1'b0;
        end else begin
            sysid_address <= sysid_address_nxt_s;
            id_value      <= id_value_nxt_s;
            timestamp     <= timestamp_nxt_s;
            busy          <= busy_nxt_s;
            done          <= done_nxt_s;
            id_ok         <= id_ok_nxt_s;
            ts_ok         <= ts_ok_nxt_s;
            mismatch      <= mismatch_nxt_s;
            retry_count   <= retry_count_nxt_s;
            system_enable <= system_enable_nxt_s;
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed self-checking bench for sysid_checker with a behavioural sysid slave.
module tb_sysid_checker;

    localparam logic [31:0] GOOD_TS = 32'h61BA5C1D;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        sysid_address;
    logic [31:0] sysid_readdata;
    logic [31:0] id_value;
    logic [31:0] timestamp;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        mismatch;
    logic [1:0]  retry_count;
    logic        system_enable;

    logic [31:0] slave_ts;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    // Combinational sysid slave
    assign sysid_readdata = sysid_address ? slave_ts : 32'h0000_0000;

    sysid_checker #(
        .RECHECK_PERIOD (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .sysid_address  (sysid_address),
        .sysid_readdata (sysid_readdata),
        .id_value       (id_value),
        .timestamp      (timestamp),
        .busy           (busy),
        .done           (done),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .mismatch       (mismatch),
        .retry_count    (retry_count),
        .system_enable  (system_enable)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %0s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".addr"},   {31'd0, sysid_address}, 32'd0);
        check({tag, ".id"},     id_value, 32'd0);
        check({tag, ".ts"},     timestamp, 32'd0);
        check({tag, ".busy"},   {31'd0, busy}, 32'd1);
        check({tag, ".done"},   {31'd0, done}, 32'd0);
        check({tag, ".id_ok"},  {31'd0, id_ok}, 32'd0);
        check({tag, ".ts_ok"},  {31'd0, ts_ok}, 32'd0);
        check({tag, ".mism"},   {31'd0, mismatch}, 32'd0);
        check({tag, ".retry"},  {30'd0, retry_count}, 32'd0);
        check({tag, ".sysen"},  {31'd0, system_enable}, 32'd0);
    endtask

    task automatic check_pass(input string tag, input logic [1:0] retries);
        check({tag, ".done"},  {31'd0, done}, 32'd1);
        check({tag, ".sysen"}, {31'd0, system_enable}, 32'd1);
        check({tag, ".busy"},  {31'd0, busy}, 32'd0);
        check({tag, ".id_ok"}, {31'd0, id_ok}, 32'd1);
        check({tag, ".ts_ok"}, {31'd0, ts_ok}, 32'd1);
        check({tag, ".mism"},  {31'd0, mismatch}, 32'd0);
        check({tag, ".retry"}, {30'd0, retry_count}, {30'd0, retries});
        check({tag, ".id"},    id_value, 32'd0);
        check({tag, ".ts"},    timestamp, GOOD_TS);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        slave_ts = GOOD_TS;
        tick(3);
        check_reset_state("rst");

        // Boot check; start pulse on cycle 3 must be ignored
        reset = 1'b0;
        check("c1.addr", {31'd0, sysid_address}, 32'd0);
        tick(1);
        check("c2.addr", {31'd0, sysid_address}, 32'd0);
        tick(1);
        check("c3.addr", {31'd0, sysid_address}, 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("c4.addr", {31'd0, sysid_address}, 32'd1);
        tick(1);
        check("c5.busy", {31'd0, busy}, 32'd1);
        check("c5.done", {31'd0, done}, 32'd0);
        tick(1);
        check_pass("boot", 2'd0);

        // Recheck from PASS: enable held, pass again after five cycles
        pulse_start();
        check("re.busy",  {31'd0, busy}, 32'd1);
        check("re.done",  {31'd0, done}, 32'd0);
        check("re.sysen", {31'd0, system_enable}, 32'd1);
        tick(4);
        check("re5.done", {31'd0, done}, 32'd0);
        tick(1);
        check_pass("re", 2'd0);

        // Persistently bad timestamp: four attempts then FAIL
        slave_ts = 32'h0000_0000;
        pulse_start();
        tick(19);
        check("bad20.busy",  {31'd0, busy}, 32'd1);
        check("bad20.sysen", {31'd0, system_enable}, 32'd1);
        check("bad20.retry", {30'd0, retry_count}, 32'd3);
        tick(1);
        check("bad.mism",  {31'd0, mismatch}, 32'd1);
        check("bad.id_ok", {31'd0, id_ok}, 32'd1);
        check("bad.ts_ok", {31'd0, ts_ok}, 32'd0);
        check("bad.retry", {30'd0, retry_count}, 32'd3);
        check("bad.sysen", {31'd0, system_enable}, 32'd0);
        check("bad.done",  {31'd0, done}, 32'd0);
        check("bad.busy",  {31'd0, busy}, 32'd0);
        tick(3);
        check("bad.sticky", {31'd0, mismatch}, 32'd1);

        // Bad first attempt, good second: pass after ten cycles with one retry
        pulse_start();
        check("rt1.mism",  {31'd0, mismatch}, 32'd0);
        check("rt1.retry", {30'd0, retry_count}, 32'd0);
        check("rt1.sysen", {31'd0, system_enable}, 32'd0);
        tick(4);
        slave_ts = GOOD_TS;
        tick(1);
        check("rt6.retry", {30'd0, retry_count}, 32'd1);
        check("rt6.ts_ok", {31'd0, ts_ok}, 32'd0);
        tick(4);
        check("rt10.done", {31'd0, done}, 32'd0);
        tick(1);
        check_pass("rt", 2'd1);

        // Reset during S_ADDR1, then a full rerun
        pulse_start();
        tick(2);
        check("mid.addr", {31'd0, sysid_address}, 32'd1);
        reset = 1'b1;
        tick(1);
        check_reset_state("midrst");
        reset = 1'b0;
        tick(5);
        check_pass("rerun", 2'd0);

`ifdef SYSID_CHECKER_PERIODIC_EN
        // PASS entered on the current cycle; recheck fires 16 cycles later
        tick(15);
        check("per15.busy", {31'd0, busy}, 32'd0);
        tick(1);
        check("per16.busy", {31'd0, busy}, 32'd1);
        tick(5);
        check_pass("per", 2'd0);
        // start coincides with the timer terminal count
        tick(15);
        pulse_start();
        check("co.busy", {31'd0, busy}, 32'd1);
        tick(5);
        check_pass("co", 2'd0);
        tick(10);
        check("co.idle", {31'd0, busy}, 32'd0);
`else
        // Without the timer PASS is held indefinitely
        tick(40);
        check("hold.busy", {31'd0, busy}, 32'd0);
        check("hold.done", {31'd0, done}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
